// File: rtl/vga_scanout_ctrl.sv
// rtl/vga_scanout_ctrl.sv - VGA timing, front-buffer scanout and vsync-aligned double-buffer flip.
// Optional SCANOUT_PIXEL_DOUBLE_EN: half-resolution framebuffer, each pixel and line shown twice.
module vga_scanout_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int ADDR_W   = 20,
    parameter int COLOR_W  = 12,
    parameter logic [ADDR_W-1:0] FB_BASE0 = '0,
    parameter logic [ADDR_W-1:0] FB_BASE1 = 'h4B000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flip,
    output logic               vsync,
    output logic               flip_done,
    output logic               front_sel,
    output logic               fb_rd_en,
    output logic [ADDR_W-1:0]  fb_rd_addr,
    input  logic [COLOR_W-1:0] fb_rd_data,
    output logic               vga_hs,
    output logic               vga_vs,
    output logic [COLOR_W-1:0] vga_rgb
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    // Stage 0: counter position presented this cycle, with its read request and sync levels.
    logic              run;
    logic [HW-1:0]     hcnt;
    logic [VW-1:0]     vcnt;
    logic              pos_act;
    logic              pos_hs;
    logic              pos_vs;

    // Stage 1: position delayed by one cycle, aligned with fb_rd_data.
    logic              act_d1;
    logic              rd_d1;
    logic              hs_d1;
    logic              vs_d1;
    logic [COLOR_W-1:0] pix_hold;

    logic              front_q;
    logic              flip_pending;
    logic              swap;

    logic [HW-1:0]     h_nxt;
    logic [VW-1:0]     v_nxt;
    logic              act_nxt;
    logic              hs_nxt;
    logic              vs_nxt;
    logic              vsync_nxt;
    logic              frame_start;
    logic              rd_nxt;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] addr_nxt;

`ifdef SCANOUT_PIXEL_DOUBLE_EN
    localparam logic [ADDR_W-1:0] HALF_W = ADDR_W'(H_ACTIVE / 2);
    logic [ADDR_W-1:0] line_base;
    logic [ADDR_W-1:0] line_nxt;
`endif

    assign base = front_q ? FB_BASE1 : FB_BASE0;

    // The first cycle after reset presents (0,0) rather than advancing past it.
    always_comb begin
        h_nxt = '0;
        v_nxt = '0;
        if (run) begin
            if (hcnt == H_LAST) begin
                h_nxt = '0;
                v_nxt = (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
            end else begin
                h_nxt = hcnt + 1'b1;
                v_nxt = vcnt;
            end
        end
        act_nxt     = (h_nxt < H_ACT) && (v_nxt < V_ACT);
        hs_nxt      = !((h_nxt >= HS_BEG) && (h_nxt < HS_END));
        vs_nxt      = !((v_nxt >= VS_BEG) && (v_nxt < VS_END));
        vsync_nxt   = (h_nxt == '0) && (v_nxt == V_ACT);
        frame_start = (h_nxt == '0) && (v_nxt == '0);
    end

`ifdef SCANOUT_PIXEL_DOUBLE_EN
    // Odd lines rewind to the start of the previous line so each source line is shown twice.
    always_comb begin
        rd_nxt   = act_nxt && !h_nxt[0];
        addr_nxt = fb_rd_addr;
        line_nxt = line_base;
        if (frame_start) begin
            addr_nxt = base;
            line_nxt = base;
        end else if (act_nxt && (h_nxt == '0)) begin
            if (v_nxt[0]) begin
                addr_nxt = line_base;
            end else begin
                addr_nxt = line_base + HALF_W;
                line_nxt = line_base + HALF_W;
            end
        end else if (rd_nxt) begin
            addr_nxt = fb_rd_addr + 1'b1;
        end
    end
`else
    always_comb begin
        rd_nxt   = act_nxt;
        addr_nxt = fb_rd_addr;
        if (frame_start) begin
            addr_nxt = base;
        end else if (act_nxt) begin
            addr_nxt = fb_rd_addr + 1'b1;
        end
    end
`endif

    // A flip in the vsync cycle itself is honoured, so the swap is visible combinationally.
    assign swap      = vsync && (flip_pending || flip);
    assign front_sel = front_q ^ swap;

    always_ff @(posedge clk) begin
        if (reset) begin
            run          <= 1'b0;
            hcnt         <= '0;
            vcnt         <= '0;
            pos_act      <= 1'b0;
            pos_hs       <= 1'b1;
            pos_vs       <= 1'b1;
            vsync        <= 1'b0;
            fb_rd_en     <= 1'b0;
            fb_rd_addr   <= FB_BASE0;
            front_q      <= 1'b0;
            flip_pending <= 1'b0;
            flip_done    <= 1'b0;
            act_d1       <= 1'b0;
            rd_d1        <= 1'b0;
            hs_d1        <= 1'b1;
            vs_d1        <= 1'b1;
            pix_hold     <= '0;
            vga_rgb      <= '0;
            vga_hs       <= 1'b1;
            vga_vs       <= 1'b1;
`ifdef SCANOUT_PIXEL_DOUBLE_EN
            line_base    <= FB_BASE0;
`endif
        end else begin
            run        <= 1'b1;
            hcnt       <= h_nxt;
            vcnt       <= v_nxt;
            pos_act    <= act_nxt;
            pos_hs     <= hs_nxt;
            pos_vs     <= vs_nxt;
            vsync      <= vsync_nxt;
            fb_rd_en   <= rd_nxt;
            fb_rd_addr <= addr_nxt;
`ifdef SCANOUT_PIXEL_DOUBLE_EN
            line_base  <= line_nxt;
`endif

            if (swap) begin
                front_q      <= ~front_q;
                flip_pending <= 1'b0;
            end else if (flip) begin
                flip_pending <= 1'b1;
            end
            flip_done <= swap;

            act_d1 <= pos_act;
            rd_d1  <= fb_rd_en;
            hs_d1  <= pos_hs;
            vs_d1  <= pos_vs;
            if (rd_d1) begin
                pix_hold <= fb_rd_data;
            end
            // Cycles without a fresh read (odd pixels when doubling) reuse the last word.
            vga_rgb <= act_d1 ? (rd_d1 ? fb_rd_data : pix_hold) : '0;
            vga_hs  <= hs_d1;
            vga_vs  <= vs_d1;
        end
    end

endmodule

// File: tb/tb_vga_scanout_ctrl.sv
// tb/tb_vga_scanout_ctrl.sv - scoreboard bench for vga_scanout_ctrl on a 14x7 timing grid.
// Honours SCANOUT_PIXEL_DOUBLE_EN to match the RTL build.
module tb_vga_scanout_ctrl;

    localparam int HT = 14;
    localparam int VT = 7;
    localparam int FRAME = HT * VT;

    typedef struct packed {
        logic vsync;
        logic done;
        logic front;
        logic rd_en;
        logic rst_chk;
    } ctl_t;

    typedef struct packed {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
    } pin_t;

    localparam pin_t IDLE = '{rgb: 12'd0, hs: 1'b1, vs: 1'b1};

    logic        clk = 1'b0;
    logic        reset;
    logic        flip;
    logic        vsync;
    logic        flip_done;
    logic        front_sel;
    logic        fb_rd_en;
    logic [19:0] fb_rd_addr;
    logic [11:0] fb_rd_data;
    logic        vga_hs;
    logic        vga_vs;
    logic [11:0] vga_rgb;

    ctl_t        ctl_q[$];
    pin_t        pin_q[$];
    logic [19:0] rd_q[$];

    int total = 0;
    int bad   = 0;
    int k     = 0;
    bit m_front = 1'b0;
    bit m_pend  = 1'b0;
    bit m_done  = 1'b0;
    bit mon_on  = 1'b0;

    vga_scanout_ctrl #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .ADDR_W(20), .COLOR_W(12),
        .FB_BASE0(20'd0), .FB_BASE1(20'd64)
    ) dut (
        .clk(clk),
        .reset(reset),
        .flip(flip),
        .vsync(vsync),
        .flip_done(flip_done),
        .front_sel(front_sel),
        .fb_rd_en(fb_rd_en),
        .fb_rd_addr(fb_rd_addr),
        .fb_rd_data(fb_rd_data),
        .vga_hs(vga_hs),
        .vga_vs(vga_vs),
        .vga_rgb(vga_rgb)
    );

    always #5 clk = ~clk;

    // Framebuffer: word at address a holds a ^ 'hA5; junk when no read was issued.
    always @(posedge clk) begin
        fb_rd_data <= fb_rd_en ? 12'(fb_rd_addr ^ 20'hA5) : 12'($urandom);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at k=%0d: actual=%0h required=%0h", name, k, act, exp);
        end
    endtask

    task automatic underflow(input string name);
        total++;
        bad++;
        $display("FAIL %s: DUT output with no expectation queued (k=%0d)", name, k);
    endtask

    always @(negedge clk) begin : monitor
        ctl_t ec;
        pin_t ep;
        if (mon_on) begin
            if (ctl_q.size() == 0) begin
                underflow("ctl_queue");
            end else begin
                ec = ctl_q.pop_front();
                chk("vsync", 32'(vsync), 32'(ec.vsync));
                chk("flip_done", 32'(flip_done), 32'(ec.done));
                chk("front_sel", 32'(front_sel), 32'(ec.front));
                chk("fb_rd_en", 32'(fb_rd_en), 32'(ec.rd_en));
                if (ec.rst_chk) chk("reset_addr", 32'(fb_rd_addr), 32'd0);
            end
            if (fb_rd_en === 1'b1) begin
                if (rd_q.size() == 0) underflow("rd_queue");
                else chk("fb_rd_addr", 32'(fb_rd_addr), 32'(rd_q.pop_front()));
            end
            if (pin_q.size() == 0) begin
                underflow("pin_queue");
            end else begin
                ep = pin_q.pop_front();
                chk("vga_rgb", 32'(vga_rgb), 32'(ep.rgb));
                chk("vga_hs", 32'(vga_hs), 32'(ep.hs));
                chk("vga_vs", 32'(vga_vs), 32'(ep.vs));
            end
        end
    end

    // One cycle held in or just out of reset: every output at its reset value.
    task automatic dead_cycle(input bit first, input bit rst);
        reset  = rst;
        flip   = 1'b0;
        mon_on = 1'b1;
        if (first) begin
            pin_q.delete();
            rd_q.delete();
            pin_q.push_back(IDLE);
            pin_q.push_back(IDLE);
        end
        pin_q.push_back(IDLE);
        ctl_q.push_back('{vsync: 1'b0, done: 1'b0, front: 1'b0, rd_en: 1'b0, rst_chk: 1'b1});
        k = 0;
        m_front = 1'b0;
        m_pend  = 1'b0;
        m_done  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Reference model: k counts pixel clocks since the first post-reset position (0,0).
    task automatic run_cycle(input bit fl, input bit rst);
        int h, v;
        bit act, rd, vsc, swp;
        logic [19:0] addr, base;
        flip  = fl;
        reset = rst;
        h = k % HT;
        v = (k / HT) % VT;
        act  = (h < 8) && (v < 4);
        base = m_front ? 20'd64 : 20'd0;
`ifdef SCANOUT_PIXEL_DOUBLE_EN
        addr = base + 20'((v / 2) * 4 + h / 2);
        rd   = act && (h % 2 == 0);
`else
        addr = base + 20'(v * 8 + h);
        rd   = act;
`endif
        vsc = (h == 0) && (v == 4);
        swp = vsc && (m_pend || fl);
        ctl_q.push_back('{vsync: vsc, done: m_done, front: m_front ^ swp, rd_en: rd, rst_chk: 1'b0});
        if (rd) rd_q.push_back(addr);
        pin_q.push_back('{rgb: act ? 12'(addr ^ 20'hA5) : 12'd0,
                          hs: !((h >= 10) && (h < 12)),
                          vs: (v != 5)});
        m_done = swp;
        if (swp) begin
            m_front = !m_front;
            m_pend  = 1'b0;
        end else if (fl) begin
            m_pend = 1'b1;
        end
        k++;
        @(posedge clk);
        #1;
    endtask

    function automatic bit pick_flip(input int i);
        int f, p;
        f = i / FRAME;
        p = i % FRAME;
        case (f)
            0:       return 1'b0;
            1:       return p == 14;
            2:       return p == 56;
            3:       return p == 57;
            4:       return 1'b0;
            5:       return (p == 3) || (p == 20) || (p == 40);
            default: return $urandom_range(0, 39) == 0;
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        flip  = 1'b0;
        @(posedge clk);
        #1;
        dead_cycle(1'b1, 1'b1);
        dead_cycle(1'b0, 1'b1);
        dead_cycle(1'b0, 1'b0);
        for (int i = 0; i < 10 * FRAME; i++) run_cycle(pick_flip(i), 1'b0);
        // Mid-frame reset raised while position (5,2) is presented, held for three edges.
        for (int i = 0; i < 2 * HT + 5; i++) run_cycle(1'b0, 1'b0);
        run_cycle(1'b0, 1'b1);
        dead_cycle(1'b1, 1'b1);
        dead_cycle(1'b0, 1'b1);
        dead_cycle(1'b0, 1'b0);
        for (int i = 0; i < 3 * FRAME; i++) run_cycle($urandom_range(0, 29) == 0, 1'b0);
        chk("rd_queue_drained", 32'(rd_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
